// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD BCD digit writer.
// HD44780 command/ASCII codes used when building the numeric field.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE2_BASE    = 8'h40;
  localparam logic [7:0] ASCII_ZERO        = 8'h30;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_QMARK       = 8'h3F;

  // Writer sequence: idle, address command, four characters, done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CHAR = 2'd2,
    DONE = 2'd3
  } wr_state_t;

endpackage

// File: rtl/lcd_bcd_to_ascii.sv
// Combinational BCD digit to HD44780 character code.
// Digits 0..9 become '0'..'9', invalid codes 10..15 become '?',
// and a raised blank flag forces a space regardless of the digit.
module lcd_bcd_to_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] ascii
);

  // Select space, digit character or question mark.
  always_comb begin
    ascii = ASCII_QMARK;
    if (blank) begin
      ascii = ASCII_SPACE;
    end else if (digit <= 4'd9) begin
      ascii = ASCII_ZERO + {4'b0000, digit};
    end
  end

endmodule

// File: rtl/lcd_bcd_digit_writer.sv
// Writes a captured 4-digit BCD value to a fixed HD44780 position:
// one set-DDRAM-address command followed by four character bytes,
// offered over a valid/ready handshake.
// Optional build macro LCD_BLANK_LEADING_ZERO_EN turns leading zeros
// (thou, hund, tens) into spaces; ones is always printed.
module lcd_bcd_digit_writer
  import lcd_pkg::*;
#(
  parameter int ROW = 0,
  parameter int COL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] thou,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       out_valid,
  output logic       out_rs,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  // Address command for the first character cell of the field.
  localparam logic [7:0] ADDR_CMD =
    LCD_CMD_SET_DDRAM | (((ROW != 0) ? LCD_LINE2_BASE : 8'h00) + 8'(COL));

  wr_state_t  state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  // digit_reg[3] = thou ... digit_reg[0] = ones, matching the index countdown.
  logic [3:0] digit_reg [4];
  logic [3:0] blank_vec;
  logic [7:0] char_ascii;

`ifdef LCD_BLANK_LEADING_ZERO_EN
  logic [3:0] zero_vec;

  // A digit is blanked when it and every higher digit are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
      assign zero_vec[gi] = (digit_reg[gi] == 4'd0);
    end
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank_vec[gi] = &zero_vec[3:gi];
    end
  endgenerate
  assign blank_vec[0] = 1'b0;
`else
  assign blank_vec = 4'b0000;
`endif

  lcd_bcd_to_ascii u_to_ascii (
    .digit (digit_reg[idx_reg]),
    .blank (blank_vec[idx_reg]),
    .ascii (char_ascii)
  );

  // State, index and digit capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        digit_reg[i] <= 4'd0;
      end
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == IDLE && start) begin
        digit_reg[3] <= thou;
        digit_reg[2] <= hund;
        digit_reg[1] <= tens;
        digit_reg[0] <= ones;
      end
    end
  end

  // Next-state logic and Moore-style handshake outputs.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    out_valid  = 1'b0;
    out_rs     = 1'b0;
    out_data   = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = ADDR_CMD;
        if (out_ready) begin
          state_next = CHAR;
          idx_next   = 2'd3;
        end
      end
      CHAR: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_rs    = 1'b1;
        out_data  = char_ascii;
        if (out_ready) begin
          if (idx_reg == 2'd0) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg - 2'd1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_bcd_digit_writer.sv
// Directed self-checking bench for lcd_bcd_digit_writer.
// Two instances: ROW=0/COL=0 and ROW=1/COL=5. Expected bytes depend on
// whether LCD_BLANK_LEADING_ZERO_EN is defined for the build.
module tb_lcd_bcd_digit_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [3:0] thou, hund, tens, ones;
  logic       out_ready;

  logic       va, rsa, busya, donea;
  logic [7:0] da;
  logic       vb, rsb, busyb, doneb;
  logic [7:0] db;

  int sel;
  logic       v, rs, busy, done;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;

  logic [8:0] byte_q   [8];
  int         byte_cyc [8];
  int         nbytes, ndone, done_cyc, unstable, extra;
  logic [15:0] busy_mask;

  always #5 clk = ~clk;

  lcd_bcd_digit_writer #(.ROW(0), .COL(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .thou(thou), .hund(hund), .tens(tens), .ones(ones),
    .out_valid(va), .out_rs(rsa), .out_data(da), .out_ready(out_ready),
    .busy(busya), .done(donea)
  );

  lcd_bcd_digit_writer #(.ROW(1), .COL(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .thou(thou), .hund(hund), .tens(tens), .ones(ones),
    .out_valid(vb), .out_rs(rsb), .out_data(db), .out_ready(out_ready),
    .busy(busyb), .done(doneb)
  );

  always_comb begin
    v    = (sel == 1) ? vb    : va;
    rs   = (sel == 1) ? rsb   : rsa;
    data = (sel == 1) ? db    : da;
    busy = (sel == 1) ? busyb : busya;
    done = (sel == 1) ? doneb : donea;
  end

  task automatic set_start(input bit s);
    start_a = (sel == 0) && s;
    start_b = (sel == 1) && s;
  endtask

  // Start a sequence in the current cycle (cycle 0).
  task automatic start_seq(input logic [3:0] t, input logic [3:0] h,
                           input logic [3:0] te, input logic [3:0] o);
    @(posedge clk); #1;
    thou = t; hund = h; tens = te; ones = o;
    out_ready = 1'b1;
    set_start(1'b1);
  endtask

  // Drive out_ready and record transfers until done (plus tail cycles).
  task automatic collect(input int stall, input int mid_cyc, input int tail);
    int   wait_cnt  = 0;
    bit   got_done  = 0;
    int   remaining = 0;
    bit   pending   = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_rs   = 1'b0;
    nbytes = 0; ndone = 0; done_cyc = -1; unstable = 0; extra = 0;
    busy_mask = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (cyc == mid_cyc) begin
        thou = 4'd5; hund = 4'd5; tens = 4'd5; ones = 4'd5;
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      if (cyc < 16 && busy === 1'b1) busy_mask[cyc] = 1'b1;
      if (v === 1'b1) begin
        if (pending && (data !== prev_data || rs !== prev_rs)) unstable++;
        if (got_done) extra++;
        if (wait_cnt >= stall) begin
          out_ready = 1'b1;
          if (nbytes < 8) begin
            byte_q[nbytes]   = {rs, data};
            byte_cyc[nbytes] = cyc;
          end
          $display("cycle %0d: byte %0d rs=%0b data=%02h", cyc, nbytes, rs, data);
          nbytes++;
          wait_cnt = 0;
          pending  = 0;
        end else begin
          out_ready = 1'b0;
          wait_cnt++;
          pending   = 1;
          prev_data = data;
          prev_rs   = rs;
        end
      end else begin
        out_ready = 1'b1;
        pending   = 0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (!got_done) begin
          got_done  = 1;
          done_cyc  = cyc;
          remaining = tail;
        end
      end
      if (got_done) begin
        if (remaining == 0) break;
        remaining--;
      end
    end
  endtask

  // Compare captured bytes against five expected (rs,data) pairs.
  task automatic check_bytes(input string name, input logic [8:0] e0,
                             input logic [8:0] e1, input logic [8:0] e2,
                             input logic [8:0] e3, input logic [8:0] e4);
    logic [8:0] exp_b [5];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3; exp_b[4] = e4;
    checks++;
    if (nbytes !== 5) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected 5", name, nbytes);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (byte_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %03h expected %03h", name, i, byte_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset;
    sel = 0;
    reset = 1'b1; out_ready = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    thou = 4'd0; hund = 4'd0; tens = 4'd0; ones = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({va, rsa, da, busya, donea} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a: got v=%b rs=%b d=%02h busy=%b done=%b expected all 0",
               va, rsa, da, busya, donea);
    end
    checks++;
    if ({vb, rsb, db, busyb, doneb} !== 12'h000) begin
      errors++;
      $display("FAIL reset_b: got v=%b rs=%b d=%02h busy=%b done=%b expected all 0",
               vb, rsb, db, busyb, doneb);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    sel = 0;
    start_seq(4'd1, 4'd2, 4'd3, 4'd4);
    collect(0, 0, 2);
    check_bytes("basic", 9'h080, 9'h131, 9'h132, 9'h133, 9'h134);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (byte_cyc[i] !== i + 1) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %0d expected %0d", i, byte_cyc[i], i + 1);
      end
    end
    checks++;
    if (done_cyc !== 6 || ndone !== 1 || extra !== 0) begin
      errors++;
      $display("FAIL basic_done: got cyc=%0d count=%0d extra=%0d expected cyc=6 count=1 extra=0",
               done_cyc, ndone, extra);
    end
    checks++;
    if (busy_mask[7:0] !== 8'b0011_1110) begin
      errors++;
      $display("FAIL basic_busy: got %08b expected 00111110", busy_mask[7:0]);
    end
  endtask

  task automatic test_row_col;
    sel = 1;
    start_seq(4'd0, 4'd0, 4'd0, 4'd7);
    collect(0, 0, 0);
`ifdef LCD_BLANK_LEADING_ZERO_EN
    check_bytes("rowcol_0007", 9'h0C5, 9'h120, 9'h120, 9'h120, 9'h137);
`else
    check_bytes("rowcol_0007", 9'h0C5, 9'h130, 9'h130, 9'h130, 9'h137);
`endif
    start_seq(4'd0, 4'd0, 4'd0, 4'd0);
    collect(0, 0, 0);
`ifdef LCD_BLANK_LEADING_ZERO_EN
    check_bytes("rowcol_0000", 9'h0C5, 9'h120, 9'h120, 9'h120, 9'h130);
`else
    check_bytes("rowcol_0000", 9'h0C5, 9'h130, 9'h130, 9'h130, 9'h130);
`endif
    sel = 0;
  endtask

  task automatic test_backpressure;
    sel = 0;
    start_seq(4'd9, 4'd8, 4'd7, 4'd6);
    collect(3, 0, 3);
    check_bytes("bp", 9'h080, 9'h139, 9'h138, 9'h137, 9'h136);
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable);
    end
    checks++;
    if (byte_cyc[4] !== 20 || done_cyc !== 21) begin
      errors++;
      $display("FAIL bp_timing: got last=%0d done=%0d expected last=20 done=21",
               byte_cyc[4], done_cyc);
    end
    checks++;
    if (ndone !== 1 || extra !== 0) begin
      errors++;
      $display("FAIL bp_done_count: got done=%0d extra=%0d expected 1 and 0", ndone, extra);
    end
  endtask

  task automatic test_invalid;
    sel = 0;
    start_seq(4'hA, 4'd0, 4'd5, 4'hF);
    collect(0, 0, 0);
    check_bytes("invalid", 9'h080, 9'h13F, 9'h130, 9'h135, 9'h13F);
  endtask

  task automatic test_back_to_back;
    sel = 0;
    start_seq(4'd2, 4'd4, 4'd6, 4'd8);
    collect(0, 3, 0);
    check_bytes("busy_start", 9'h080, 9'h132, 9'h134, 9'h136, 9'h138);
    // Start in the cycle right after done.
    start_seq(4'd5, 4'd5, 4'd5, 4'd5);
    collect(0, 0, 1);
    check_bytes("restart", 9'h080, 9'h135, 9'h135, 9'h135, 9'h135);
    checks++;
    if (byte_cyc[0] !== 1 || done_cyc !== 6 || extra !== 0) begin
      errors++;
      $display("FAIL restart_timing: got first=%0d done=%0d extra=%0d expected 1 6 0",
               byte_cyc[0], done_cyc, extra);
    end
  endtask

  task automatic test_start_in_done;
    sel = 0;
    start_seq(4'd1, 4'd1, 4'd1, 4'd1);
    collect(0, 0, 0);
    set_start(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_start(1'b0);
      checks++;
      if (v !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL start_in_done%0d: got v=%b busy=%b expected 0 0", i, v, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    sel = 0;
    start_seq(4'd1, 4'd2, 4'd3, 4'd4);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      set_start(1'b0);
      out_ready = 1'b1;
    end
    checks++;
    if (v !== 1'b1 || data !== 8'h32) begin
      errors++;
      $display("FAIL reset_mid_pre: got v=%b data=%02h expected 1 32", v, data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (v !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: got v=%b busy=%b done=%b expected 0 0 0", v, busy, done);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (v !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d: got v=%b done=%b expected 0 0", i, v, done);
      end
    end
    start_seq(4'd3, 4'd0, 4'd0, 4'd1);
    collect(0, 0, 0);
    check_bytes("reset_restart", 9'h080, 9'h133, 9'h130, 9'h130, 9'h131);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_row_col;
    test_backpressure;
    test_invalid;
    test_back_to_back;
    test_start_in_done;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
